// File: rtl/reset_seq_pkg.sv
// ============================================================================
// reset_seq_pkg
//   Shared state encoding and counter sizing for the fabric reset sequencer.
//   Revision: 1.0
// ============================================================================
`default_nettype none

package reset_seq_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_PWR  = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_PD_RETRY  = 3'd2,
        ST_WAIT_INIT = 3'd3,
        ST_RELEASE   = 3'd4,
        ST_RUN       = 3'd5,
        ST_FAULT     = 3'd6
    } state_t;

    // Width able to hold the largest of four terminal counts without wrapping
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/reset_sync_filter.sv
// ============================================================================
// reset_sync_filter
//   Per-bit synchronizer with an AND-reduced stable-high filter on the output.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module reset_sync_filter #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2,
    parameter int FILT        = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic             all_high,
    output logic             stable
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign all_high = &sync_q[SYNC_STAGES-1];

    generate
        if (FILT == 0) begin : g_nofilt
            assign stable = all_high & ~clr;
        end else begin : g_filt
            localparam int CW = $clog2(FILT + 1);
            logic [CW-1:0] cnt;

            // Counts consecutive high samples, saturating; any low sample restarts it
            always_ff @(posedge clk) begin
                if (!rst_n || clr || !all_high) begin
                    cnt <= '0;
                end else if (cnt != CW'(FILT)) begin
                    cnt <= cnt + 1'b1;
                end
            end

            // The current sample completes the run of FILT highs
            assign stable = all_high & ~clr & (cnt >= CW'(FILT - 1));
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/reset_sequencer_pf.sv
// ============================================================================
// reset_sequencer_pf
//   Multi-domain fabric reset sequencer with lock filtering and PLL retry.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module reset_sequencer_pf
    import reset_seq_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int N_PLL        = 2,
    parameter int N_BANK       = 2,
    parameter int SYNC_STAGES  = 2,
    parameter int LOCK_FILT    = 16,
    parameter int STAGE_DLY    = 8,
    parameter int LOCK_TIMEOUT = 1000,
    parameter int PD_CYCLES    = 32,
    parameter int MAX_RETRY    = 3
) (
    input  logic                             CLK,
    input  logic                             EXT_RST_N,
    input  logic                             FPGA_POR_N,
    input  logic [N_BANK-1:0]                BANK_VDDI_STATUS,
    input  logic [N_PLL-1:0]                 PLL_LOCK,
    input  logic                             INIT_DONE,
    input  logic                             SS_BUSY,
    input  logic                             FF_US_RESTORE,
    output logic [N_CH-1:0]                  RESET_N,
    output logic                             PLL_POWERDOWN_B,
    output logic                             READY,
    output logic                             FAULT,
    output logic [$clog2(MAX_RETRY+1)-1:0]   RETRY_CNT
);

    localparam int TW = cnt_width(LOCK_TIMEOUT, PD_CYCLES, N_CH * STAGE_DLY, LOCK_FILT);
    localparam int RW = $clog2(MAX_RETRY + 1);

    logic pwr_ok, pwr_all, lock_ok, lock_all, init_go, init_all, lock_clr;
    logic unused_sync;

    reset_sync_filter #(.WIDTH(1 + N_BANK), .SYNC_STAGES(SYNC_STAGES), .FILT(0)) u_pwr_sync (
        .clk      (CLK),
        .rst_n    (EXT_RST_N),
        .clr      (1'b0),
        .din      ({FPGA_POR_N, BANK_VDDI_STATUS}),
        .all_high (pwr_all),
        .stable   (pwr_ok)
    );

    reset_sync_filter #(.WIDTH(N_PLL), .SYNC_STAGES(SYNC_STAGES), .FILT(LOCK_FILT)) u_lock_sync (
        .clk      (CLK),
        .rst_n    (EXT_RST_N),
        .clr      (lock_clr),
        .din      (PLL_LOCK),
        .all_high (lock_all),
        .stable   (lock_ok)
    );

    // Blockers are inverted so the AND reduction means "clear to release"
    reset_sync_filter #(.WIDTH(3), .SYNC_STAGES(SYNC_STAGES), .FILT(0)) u_init_sync (
        .clk      (CLK),
        .rst_n    (EXT_RST_N),
        .clr      (1'b0),
        .din      ({INIT_DONE, ~SS_BUSY, ~FF_US_RESTORE}),
        .all_high (init_all),
        .stable   (init_go)
    );

    assign unused_sync = pwr_all ^ init_all;

    state_t          state, state_nx;
    logic [TW-1:0]   timer, timer_nx;
    logic [RW-1:0]   retry_nx;
    logic [N_CH-1:0] rst_nx;
    logic            ready_nx, fault_nx, pd_nx;

    always_ff @(posedge CLK) begin
        if (!EXT_RST_N) begin
            state           <= ST_WAIT_PWR;
            timer           <= '0;
            RETRY_CNT       <= '0;
            RESET_N         <= '0;
            READY           <= 1'b0;
            FAULT           <= 1'b0;
            PLL_POWERDOWN_B <= 1'b0;
        end else begin
            state           <= state_nx;
            timer           <= timer_nx;
            RETRY_CNT       <= retry_nx;
            RESET_N         <= rst_nx;
            READY           <= ready_nx;
            FAULT           <= fault_nx;
            PLL_POWERDOWN_B <= pd_nx;
        end
    end

    always_comb begin
        state_nx = state;
        timer_nx = timer;
        retry_nx = RETRY_CNT;
        rst_nx   = RESET_N;
        ready_nx = READY;
        fault_nx = FAULT;
        lock_clr = 1'b0;

        if (!pwr_ok && state != ST_FAULT) begin
            state_nx = ST_WAIT_PWR;
            timer_nx = '0;
            rst_nx   = '0;
            ready_nx = 1'b0;
        end else begin
            case (state)
                ST_WAIT_PWR: begin
                    state_nx = ST_WAIT_LOCK;
                    timer_nx = '0;
                end
                ST_WAIT_LOCK: begin
                    if (lock_ok) begin
                        state_nx = ST_WAIT_INIT;
                        timer_nx = '0;
                        retry_nx = '0;
                    end else if (timer == TW'(LOCK_TIMEOUT - 1)) begin
                        timer_nx = '0;
                        if (RETRY_CNT < RW'(MAX_RETRY)) begin
                            state_nx = ST_PD_RETRY;
                            retry_nx = RETRY_CNT + 1'b1;
                        end else begin
                            state_nx = ST_FAULT;
                            fault_nx = 1'b1;
                        end
                    end else begin
                        timer_nx = timer + 1'b1;
                    end
                end
                ST_PD_RETRY: begin
                    if (timer == TW'(PD_CYCLES - 1)) begin
                        state_nx = ST_WAIT_LOCK;
                        timer_nx = '0;
                        lock_clr = 1'b1;
                    end else begin
                        timer_nx = timer + 1'b1;
                    end
                end
                ST_WAIT_INIT: begin
                    if (!lock_all) begin
                        state_nx = ST_WAIT_LOCK;
                        timer_nx = '0;
                    end else if (init_go) begin
                        state_nx = ST_RELEASE;
                        timer_nx = '0;
                    end
                end
                ST_RELEASE: begin
                    if (!lock_all) begin
                        state_nx = ST_WAIT_LOCK;
                        timer_nx = '0;
                        rst_nx   = '0;
                    end else if (timer == TW'(STAGE_DLY - 1)) begin
                        // Shift a one in from ch0; the last channel completes the sequence
                        timer_nx = '0;
                        rst_nx   = N_CH'({RESET_N, 1'b1});
                        if (&rst_nx) begin
                            state_nx = ST_RUN;
                            ready_nx = 1'b1;
                        end
                    end else begin
                        timer_nx = timer + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!lock_all) begin
                        state_nx = ST_WAIT_LOCK;
                        timer_nx = '0;
                        rst_nx   = '0;
                        ready_nx = 1'b0;
                    end
                end
                ST_FAULT: begin
                    rst_nx   = '0;
                    ready_nx = 1'b0;
                    fault_nx = 1'b1;
                end
                default: begin
                    state_nx = ST_WAIT_PWR;
                    timer_nx = '0;
                    rst_nx   = '0;
                    ready_nx = 1'b0;
                end
            endcase
        end

        pd_nx = pwr_ok & (state_nx != ST_PD_RETRY);
    end

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer_pf.sv
// ============================================================================
// tb_reset_sequencer_pf
//   Scenario bench for reset_sequencer_pf against a timestamp-based model.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_reset_sequencer_pf;

    localparam int N_CH = 4, N_PLL = 2, N_BANK = 2, SYNC_STAGES = 2, LOCK_FILT = 16;
    localparam int STAGE_DLY = 8, LOCK_TIMEOUT = 1000, PD_CYCLES = 32, MAX_RETRY = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       ext_rst_n = 1'b0, por_n = 1'b0, init_done = 1'b0, ss_busy = 1'b0, ff_rest = 1'b0;
    logic [1:0] bank = '0, lock = '0;
    logic [3:0] reset_n;
    logic       pd_b, ready, fault;
    logic [1:0] retry_cnt;

    reset_sequencer_pf #(
        .N_CH(N_CH), .N_PLL(N_PLL), .N_BANK(N_BANK), .SYNC_STAGES(SYNC_STAGES),
        .LOCK_FILT(LOCK_FILT), .STAGE_DLY(STAGE_DLY), .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .PD_CYCLES(PD_CYCLES), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .CLK              (clk),
        .EXT_RST_N        (ext_rst_n),
        .FPGA_POR_N       (por_n),
        .BANK_VDDI_STATUS (bank),
        .PLL_LOCK         (lock),
        .INIT_DONE        (init_done),
        .SS_BUSY          (ss_busy),
        .FF_US_RESTORE    (ff_rest),
        .RESET_N          (reset_n),
        .PLL_POWERDOWN_B  (pd_b),
        .READY            (ready),
        .FAULT            (fault),
        .RETRY_CNT        (retry_cnt)
    );

    wire [8:0] dut_vec = {reset_n, pd_b, ready, fault, retry_cnt};

    int tests = 0, fails = 0, cyc = 0;

    // Reference model: phase plus the edge index at which it was entered
    localparam int M_PWR = 0, M_LOCK = 1, M_PD = 2, M_INIT = 3, M_REL = 4, M_RUN = 5, M_FAULT = 6;
    int         m_phase = M_PWR, m_start = 0, m_retry = 0, m_run = 0;
    logic [7:0] dly [1:SYNC_STAGES];
    logic [8:0] exp_vec = '0;

    task automatic model_edge();
        logic [7:0] s, cur;
        logic       pwr, lall, go, lok, clr;
        int         chans;
        logic [3:0] rn;
        cur  = {por_n, bank, lock, init_done, ss_busy, ff_rest};
        s    = dly[SYNC_STAGES];
        pwr  = s[7] & s[6] & s[5];
        lall = s[4] & s[3];
        go   = s[2] & ~s[1] & ~s[0];
        lok  = lall && (m_run + 1 >= LOCK_FILT);
        clr  = 1'b0;
        if (!ext_rst_n) begin
            m_phase = M_PWR; m_retry = 0; m_run = 0;
            for (int j = 1; j <= SYNC_STAGES; j++) dly[j] = '0;
            exp_vec = '0;
            return;
        end
        if (!pwr && m_phase != M_FAULT) m_phase = M_PWR;
        else case (m_phase)
            M_PWR:  begin m_phase = M_LOCK; m_start = cyc; end
            M_LOCK: if (lok) begin m_phase = M_INIT; m_retry = 0; end
                    else if (cyc - m_start >= LOCK_TIMEOUT) begin
                        if (m_retry < MAX_RETRY) begin m_phase = M_PD; m_retry++; m_start = cyc; end
                        else m_phase = M_FAULT;
                    end
            M_PD:   if (cyc - m_start >= PD_CYCLES) begin m_phase = M_LOCK; m_start = cyc; clr = 1'b1; end
            M_INIT: if (!lall) begin m_phase = M_LOCK; m_start = cyc; end
                    else if (go) begin m_phase = M_REL; m_start = cyc; end
            M_REL:  if (!lall) begin m_phase = M_LOCK; m_start = cyc; end
                    else if (cyc - m_start >= N_CH * STAGE_DLY) m_phase = M_RUN;
            M_RUN:  if (!lall) begin m_phase = M_LOCK; m_start = cyc; end
            default: ;
        endcase
        m_run = (clr || !lall) ? 0 : m_run + 1;
        for (int j = SYNC_STAGES; j > 1; j--) dly[j] = dly[j-1];
        dly[1] = cur;
        rn = '0;
        if (m_phase == M_REL) begin
            chans = (cyc - m_start) / STAGE_DLY;
            rn = 4'((1 << chans) - 1);
        end else if (m_phase == M_RUN) begin
            rn = 4'hF;
        end
        exp_vec = {rn, pwr && (m_phase != M_PD), m_phase == M_RUN, m_phase == M_FAULT, 2'(m_retry)};
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
    endtask

    task automatic set_good();
        por_n = 1'b1; bank = 2'b11; lock = 2'b11; init_done = 1'b1; ss_busy = 1'b0; ff_rest = 1'b0;
    endtask

    task automatic do_reset();
        ext_rst_n = 1'b0;
        tick(); tick();
        ext_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        ext_rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            {por_n, bank, lock, init_done, ss_busy, ff_rest} = 8'($urandom);
            tick();
            tests++;
            if (dut_vec !== 9'b0) begin
                fails++; $display("FAIL reset cyc=%0d got=%b want=%b", cyc, dut_vec, 9'b0);
            end
        end
        ext_rst_n = 1'b1;
    endtask

    task automatic test_nominal();
        set_good(); do_reset();
        for (int i = 0; i < 70; i++) begin
            tick();
            tests++;
            if (dut_vec !== exp_vec) begin
                fails++; $display("FAIL nominal cyc=%0d got=%b want=%b", cyc, dut_vec, exp_vec);
            end
        end
        tests++;
        if ({reset_n, ready} !== 5'b11111) begin
            fails++; $display("FAIL nominal_final got=%b want=11111", {reset_n, ready});
        end
    endtask

    task automatic test_lock_glitch();
        int g;
        g = $urandom_range(2, 14);
        set_good(); do_reset();
        for (int i = 0; i < 80; i++) begin
            lock[1] = (i != g);
            tick();
            tests++;
            if (dut_vec !== exp_vec) begin
                fails++; $display("FAIL lock_glitch cyc=%0d got=%b want=%b", cyc, dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_timeout();
        set_good(); lock = 2'b00; do_reset();
        for (int i = 0; i < 4 * LOCK_TIMEOUT + 3 * PD_CYCLES + 30; i++) begin
            lock = 2'($urandom_range(0, 2));
            tick();
            tests++;
            if (dut_vec !== exp_vec) begin
                fails++; $display("FAIL timeout cyc=%0d got=%b want=%b", cyc, dut_vec, exp_vec);
            end
        end
        tests++;
        if ({fault, retry_cnt} !== 3'b111) begin
            fails++; $display("FAIL timeout_fault got=%b want=111", {fault, retry_cnt});
        end
    endtask

    task automatic test_fault_exit();
        for (int i = 0; i < 20; i++) begin
            por_n = 1'($urandom); lock = 2'b11;
            tick();
            tests++;
            if (dut_vec !== exp_vec) begin
                fails++; $display("FAIL fault_sticky cyc=%0d got=%b want=%b", cyc, dut_vec, exp_vec);
            end
        end
        ext_rst_n = 1'b0;
        tick();
        tests++;
        if (dut_vec !== 9'b0) begin
            fails++; $display("FAIL fault_exit got=%b want=%b", dut_vec, 9'b0);
        end
        ext_rst_n = 1'b1;
    endtask

    task automatic test_loss_in_run();
        int k, hold;
        set_good(); lock = 2'b00; do_reset();
        for (int i = 0; i < LOCK_TIMEOUT + PD_CYCLES + 10 + 80; i++) begin
            if (i == LOCK_TIMEOUT + PD_CYCLES + 10) lock = 2'b11;
            tick();
            tests++;
            if (dut_vec !== exp_vec) begin
                fails++; $display("FAIL loss_setup cyc=%0d got=%b want=%b", cyc, dut_vec, exp_vec);
            end
        end
        tests++;
        if ({ready, retry_cnt} !== 3'b100) begin
            fails++; $display("FAIL loss_retry_clear got=%b want=100", {ready, retry_cnt});
        end
        k = $urandom_range(0, 1);
        hold = $urandom_range(0, 10);
        lock[k] = 1'b0;
        for (int i = 0; i < SYNC_STAGES + 1; i++) tick();
        tests++;
        if ({reset_n, ready} !== 5'b00000) begin
            fails++; $display("FAIL loss_drop got=%b want=00000", {reset_n, ready});
        end
        for (int i = 0; i < hold + 80; i++) begin
            if (i == hold) lock = 2'b11;
            tick();
            tests++;
            if (dut_vec !== exp_vec) begin
                fails++; $display("FAIL loss_recover cyc=%0d got=%b want=%b", cyc, dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_blockers();
        int n;
        n = $urandom_range(40, 90);
        set_good(); ss_busy = 1'b1; do_reset();
        for (int i = 0; i < n; i++) begin
            tick();
            tests++;
            if (dut_vec !== exp_vec) begin
                fails++; $display("FAIL blocker_hold cyc=%0d got=%b want=%b", cyc, dut_vec, exp_vec);
            end
        end
        tests++;
        if (reset_n !== 4'h0) begin
            fails++; $display("FAIL blocker_reset got=%b want=0000", reset_n);
        end
        for (int i = 0; i < 80; i++) begin
            {init_done, ss_busy, ff_rest} = (i < 3) ? 3'b100 : 3'($urandom);
            tick();
            tests++;
            if (dut_vec !== exp_vec) begin
                fails++; $display("FAIL blocker_release cyc=%0d got=%b want=%b", cyc, dut_vec, exp_vec);
            end
        end
        tests++;
        if ({reset_n, ready} !== 5'b11111) begin
            fails++; $display("FAIL blocker_final got=%b want=11111", {reset_n, ready});
        end
    endtask

    task automatic test_power();
        int n;
        n = $urandom_range(25, 45);
        set_good(); do_reset();
        for (int i = 0; i < n; i++) tick();
        por_n = 1'b0;
        for (int i = 0; i < SYNC_STAGES + 1; i++) tick();
        tests++;
        if ({reset_n, pd_b, ready} !== 6'b0) begin
            fails++; $display("FAIL power_drop got=%b want=000000", {reset_n, pd_b, ready});
        end
        for (int i = 0; i < 90; i++) begin
            if (i == 3) por_n = 1'b1;
            tick();
            tests++;
            if (dut_vec !== exp_vec) begin
                fails++; $display("FAIL power_recover cyc=%0d got=%b want=%b", cyc, dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_random();
        set_good(); do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3)
                {por_n, bank, lock, init_done, ss_busy, ff_rest} = 8'($urandom);
            else if ($urandom_range(0, 99) < 6)
                set_good();
            ext_rst_n = ($urandom_range(0, 499) != 0);
            tick();
            tests++;
            if (dut_vec !== exp_vec) begin
                fails++; $display("FAIL random cyc=%0d got=%b want=%b", cyc, dut_vec, exp_vec);
            end
        end
        ext_rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_lock_glitch();
        test_timeout();
        test_fault_exit();
        test_loss_in_run();
        test_blockers();
        test_power();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
